// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory fetch unit.
// Range checking is enabled by defining IMEM_RANGE_CHECK_EN.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } imem_state_t;

    localparam logic [31:0] IMEM_NOP = 32'hE1A0_0000;

    // Word-index width for a memory of the given depth (never below 1 bit).
    function automatic int imem_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Program-load FSM: write pointer, overflow detection and load status flags.
// With IMEM_RANGE_CHECK_EN defined, an out-of-range load_base aborts the load.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32,
    localparam int IDX_W = imem_idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [31:0]       wr_data,
    output imem_state_t       state
);

    // The pointer carries one extra bit so it can sit at DEPTH after the last slot.
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(DEPTH);

    imem_state_t      state_next;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic             err_next;
    logic             base_oob;
    logic [PTR_W-1:0] base_idx;

    assign base_idx = {1'b0, load_base[IDX_W+1:2]};

`ifdef IMEM_RANGE_CHECK_EN
    assign base_oob = (load_base >> 2) >= ADDR_W'(DEPTH);
    wire unused_base = ^load_base[1:0];
`else
    assign base_oob = 1'b0;
    wire unused_base = ^{load_base[ADDR_W-1:IDX_W+2], load_base[1:0]};
`endif

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        err_next   = load_err;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    ptr_next   = base_idx;
                    err_next   = base_oob;
                    state_next = base_oob ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (load_valid) begin
                    if (ptr == PTR_END) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        wr_en    = 1'b1;
                        ptr_next = ptr + PTR_W'(1);
                        if (load_last) state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            load_err  <= 1'b0;
            load_busy <= 1'b0;
            load_done <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            load_err  <= err_next;
            load_busy <= (state_next == LOAD);
            load_done <= (state_next == DONE);
        end
    end

    assign wr_idx  = ptr[IDX_W-1:0];
    assign wr_data = load_data;

endmodule

// File: rtl/imem_fetch_unit.sv
// Synchronous instruction memory with a registered fetch port and a run-time load port.
// Define IMEM_RANGE_CHECK_EN to fault misaligned or out-of-range fetches instead of wrapping.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int          DEPTH    = 64,
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] NOP_WORD = IMEM_NOP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              inst_valid,
    output logic [31:0]       instruction,
    output logic              fetch_fault,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    localparam int IDX_W = imem_idx_w(DEPTH);

    logic [31:0]      mem [DEPTH];
    imem_state_t      state;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic             accept;
    logic             fault;
    logic [IDX_W-1:0] rd_idx;

    imem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_base  (load_base),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .state      (state)
    );

    // A load_start in IDLE takes priority over a simultaneous fetch.
    assign fetch_ready = (state == IDLE) && !load_start;
    assign accept      = fetch_req && fetch_ready;
    assign rd_idx      = fetch_addr[IDX_W+1:2];

`ifdef IMEM_RANGE_CHECK_EN
    assign fault = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> 2) >= ADDR_W'(DEPTH));
`else
    assign fault = 1'b0;
    wire unused_addr = ^{fetch_addr[ADDR_W-1:IDX_W+2], fetch_addr[1:0]};
`endif

    // Array contents are deliberately not reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_valid  <= 1'b0;
            instruction <= NOP_WORD;
            fetch_fault <= 1'b0;
        end else begin
            inst_valid  <= accept;
            fetch_fault <= accept && fault;
            if (accept) instruction <= fault ? NOP_WORD : mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Self-checking bench for imem_fetch_unit: table-driven fetches, load sequences and corner cases.
module tb_imem_fetch_unit;

    localparam int          DEPTH  = 64;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] NOP    = 32'hE1A0_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              inst_valid;
    logic [31:0]       instruction;
    logic              fetch_fault;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_busy;
    logic              load_done;
    logic              load_err;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;
    int valid_cnt = 0;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [31:0] model [DEPTH];
    logic [31:0] ld_words [4];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
    } fvec_t;
    fvec_t fvec [8];

    always #5 clk = ~clk;

    imem_fetch_unit #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .fetch_fault (fetch_fault),
        .load_start  (load_start),
        .load_base   (load_base),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every valid result pops one expected {fault, word}.
    always @(negedge clk) begin
        if (!rst) begin
            if (load_done) done_cnt++;
            if (inst_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: actual=%h required=none", instruction);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("fetch_word", instruction, mon_e[31:0]);
                    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, mon_e[32]});
                end
            end
        end
    end

    function automatic logic [32:0] exp_fetch(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
`ifdef IMEM_RANGE_CHECK_EN
        if (addr[1:0] != 2'b00 || idx >= DEPTH) return {1'b1, NOP};
        return {1'b0, model[int'(idx)]};
`else
        return {1'b0, model[int'(idx % DEPTH)]};
`endif
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_inst_valid"}, inst_valid, 0);
        check({tag, "_instruction"}, instruction, NOP);
        check({tag, "_fetch_fault"}, fetch_fault, 0);
        check({tag, "_load_busy"}, load_busy, 0);
        check({tag, "_load_done"}, load_done, 0);
        check({tag, "_load_err"}, load_err, 0);
    endtask

    task automatic drive_fetch(input logic [31:0] addr, input logic [31:0] word, input logic flt);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        #1;
        check("fetch_ready", fetch_ready, 1);
        exp_q.push_back({flt, word});
        tick();
    endtask

    task automatic fetch_model(input logic [31:0] addr);
        logic [32:0] e;
        e = exp_fetch(addr);
        drive_fetch(addr, e[31:0], e[32]);
    endtask

    task automatic do_load(input logic [31:0] base, input int n, input bit collide);
        int   ptr;
        int   d0;
        logic exp_err;
        d0      = done_cnt;
        ptr     = int'(base >> 2);
        exp_err = 1'b0;
        load_start = 1'b1;
        load_base  = base;
        if (collide) begin
            fetch_req  = 1'b1;
            fetch_addr = '0;
            #1;
            check("collide_ready", fetch_ready, 0);
        end
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        if (collide) check("collide_no_valid", inst_valid, 0);
        check("busy_after_start", load_busy, 1);
        check("err_cleared", load_err, 0);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = ld_words[i];
            load_last  = (i == n - 1);
            if (ptr == DEPTH) exp_err = 1'b1;
            else begin
                model[ptr] = ld_words[i];
                ptr++;
            end
            tick();
            if (exp_err) break;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("done_pulse", load_done, 1);
        check("load_err", load_err, {31'b0, exp_err});
        check("busy_clear", load_busy, 0);
        check("ready_in_done", fetch_ready, 0);
        tick();
        check("done_low", load_done, 0);
        check("ready_back", fetch_ready, 1);
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int vc;
        int d0;
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        load_start = 1'b0; load_base = '0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;

        fvec[0] = '{32'h00, 32'hA5A5_0000};
        fvec[1] = '{32'h04, 32'hA5A5_0001};
        fvec[2] = '{32'h08, 32'hA5A5_0002};
        fvec[3] = '{32'h0C, 32'hA5A5_0003};
        fvec[4] = '{32'h10, 32'hE3A0_0014};
        fvec[5] = '{32'h14, 32'hE3A0_1A01};
        fvec[6] = '{32'h18, 32'hE3A0_2103};
        fvec[7] = '{32'h1C, 32'hE092_3002};

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        check("reset_ready", fetch_ready, 1);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) ld_words[i] = fvec[i].word;
        do_load(32'h0, 4, 1'b0);
        check("nop_before_fetch", instruction, NOP);
        check("idle_no_valid", inst_valid, 0);

        drive_fetch(32'h0, fvec[0].word, 1'b0);
        fetch_req = 1'b0;
        check("first_valid", inst_valid, 1);
        tick();

        for (int i = 0; i < 4; i++) ld_words[i] = fvec[i + 4].word;
        do_load(32'h10, 4, 1'b0);

        vc = valid_cnt;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) check("b2b_valid", inst_valid, 1);
            drive_fetch(fvec[i].addr, fvec[i].word, 1'b0);
        end
        fetch_req = 1'b0;
        tick();
        check("burst_count", valid_cnt - vc, 8);
        check("queue_drained", exp_q.size(), 0);
        check("idle_valid_low", inst_valid, 0);
        check("instruction_hold", instruction, fvec[7].word);

        ld_words[0] = 32'hCAFE_0001;
        ld_words[1] = 32'hCAFE_0002;
        do_load(32'h40, 2, 1'b1);
        fetch_model(32'h40);
        fetch_model(32'h44);
        fetch_req = 1'b0;
        tick();

        ld_words[0] = 32'hBEEF_0001;
        ld_words[1] = 32'hBEEF_0002;
        ld_words[2] = 32'hBEEF_0003;
        do_load((DEPTH - 2) * 4, 3, 1'b0);
        drive_fetch((DEPTH - 2) * 4, 32'hBEEF_0001, 1'b0);
        drive_fetch((DEPTH - 1) * 4, 32'hBEEF_0002, 1'b0);
        fetch_req = 1'b0;
        tick();
        check("err_sticky", load_err, 1);
        ld_words[0] = 32'h1234_5678;
        do_load(32'h80, 1, 1'b0);

`ifdef IMEM_RANGE_CHECK_EN
        drive_fetch(32'h102, NOP, 1'b1);
        drive_fetch(4 * DEPTH, NOP, 1'b1);
`else
        drive_fetch(4 * DEPTH, fvec[0].word, 1'b0);
        fetch_model(32'h102);
`endif
        fetch_req = 1'b0;
        tick();

        d0 = done_cnt;
        load_start = 1'b1;
        load_base  = 32'h60;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'h5A5A_0000;
        tick();
        model[24]  = 32'h5A5A_0000;
        load_data  = 32'h5A5A_0001;
        tick();
        model[25]  = 32'h5A5A_0001;
        load_data  = 32'h5A5A_0002;
        rst = 1'b1;
        #1;
        check_reset("midload");
        check("midload_queue", exp_q.size(), 0);
        tick();
        load_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("no_done_on_reset", done_cnt - d0, 0);
        check("ready_after_reset", fetch_ready, 1);
        drive_fetch(32'h60, 32'h5A5A_0000, 1'b0);
        drive_fetch(32'h64, 32'h5A5A_0001, 1'b0);
        fetch_req = 1'b0;
        tick();
        tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
# imem_fetch_unit

Parametrised, synchronous instruction memory for the ARM core's fetch stage, replacing the fixed 51-word combinational ROM. It provides a registered fetch port with a request/valid handshake and a sequential program-load port with its own state machine. Programs can therefore be downloaded at run time instead of being compiled in. It sits between the IF-stage PC register and the IF/ID pipeline register.

## Interface
- `DEPTH`, 64: number of 32-bit instruction words.
- `ADDR_W`, 32: byte-address width of `fetch_addr` and `load_base`.
- `NOP_WORD`, 32'hE1A0_0000: word returned for faulted fetches and after reset (MOV R0,R0).
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_req` in 1: fetch request for `fetch_addr`.
- `fetch_addr` in ADDR_W: byte address (PC).
- `fetch_ready` out 1: fetch port can accept a request this cycle.
- `inst_valid` out 1: `instruction` carries the result of the fetch accepted last cycle.
- `instruction` out 32: registered instruction word.
- `fetch_fault` out 1: qualifies `inst_valid`; the fetch was out of range or misaligned (see Configuration).
- `load_start` in 1: one-cycle pulse that begins a program load.
- `load_base` in ADDR_W: byte address of the first loaded word, sampled with `load_start`.
- `load_valid` in 1: `load_data` is valid this cycle.
- `load_data` in 32: instruction word to write.
- `load_last` in 1: qualifies `load_valid`; marks the final word.
- `load_busy` out 1: high while the FSM is in LOAD.
- `load_done` out 1: one-cycle pulse when a load finishes.
- `load_err` out 1: sticky overflow flag; cleared by the next accepted `load_start` or by `rst`.

## Operation
- Word index = `fetch_addr >> 2` (same for `load_base`). The index width is clog2(DEPTH).
- Memory array is not reset. Contents survive `rst`, and power-up contents are undefined.
- Fetch acceptance: a fetch is accepted when `fetch_req && fetch_ready`.
- `fetch_ready` = (state == IDLE) && !`load_start`.
  - A `load_start` arriving together with `fetch_req` in IDLE wins; the fetch is not accepted.
- Accepted fetch: the memory word is registered into `instruction`, with `inst_valid` = 1 next cycle.
- Without an accepted fetch, `inst_valid` = 0 and `instruction` holds its last value.
- FSM states:
  - IDLE: on `load_start`, capture the start index into the write pointer, clear `load_err`, go to LOAD.
  - LOAD:
    - Each `load_valid` writes `load_data` at the pointer, then increments the pointer.
    - `load_valid && load_last` → DONE.
    - `load_valid` with pointer == DEPTH: the word is dropped, `load_err` = 1, go to DONE.
    - `load_start` is ignored in this state.
  - DONE: `load_done` = 1 for one cycle, then → IDLE.
- Fetches are refused (`fetch_ready` = 0) in LOAD and DONE, so no read/write collision can occur.
- Reset mid-load: FSM → IDLE and the pointer is cleared. Words already written remain. `load_done` is not pulsed.

## Timing
- Reset values: `inst_valid` = 0, `instruction` = NOP_WORD, `fetch_fault` = 0, `load_busy` = 0, `load_done` = 0, `load_err` = 0, state = IDLE.
- Fetch latency is 1 cycle: accepted at edge N, result visible after edge N.
  - Back-to-back fetches every cycle give one result per cycle.
- Load throughput is one word per cycle with `load_valid` held high.
- `load_done` is asserted the cycle after the final write. `fetch_ready` returns the cycle after that.
- `fetch_ready` is combinational from state and `load_start`. All other outputs are registered.

## Configuration
- `IMEM_RANGE_CHECK_EN` defined:
  - A fetch with `fetch_addr[1:0]` != 0 or index ≥ DEPTH returns NOP_WORD with `fetch_fault` = 1 alongside `inst_valid`.
  - A load whose `load_base` index ≥ DEPTH sets `load_err` and goes directly to DONE.
- `IMEM_RANGE_CHECK_EN` undefined:
  - The index is truncated to clog2(DEPTH) bits and the low address bits are ignored (wrap-around).
  - `fetch_fault` is tied to 0.
  - Load overflow still sets `load_err`.

## Structure
- Package `imem_pkg` holds:
  - the `imem_state_t` enum (IDLE, LOAD, DONE);
  - the `IMEM_NOP` constant;
  - the index-width localparam helper.
- Sub-module `imem_loader` contains the FSM, write pointer, overflow logic and `load_*` flags. It outputs the write enable, index and data to the top, which owns the array and the fetch register.

## Test plan
- Reset, then a fetch of 0x0 → cycle 1: `inst_valid` = 1, and `instruction` matches the preloaded word. Before that fetch, `instruction` = 0xE1A00000.
- Load 4 words (0xE3A00014, 0xE3A01A01, 0xE3A02103, 0xE0923002) at base 0x10 with the last word flagged → `load_done` pulses once, and fetches of 0x10–0x1C return those words in order with back-to-back valids.
- Assert `load_start` and `fetch_req` in the same cycle → `fetch_ready` = 0, no `inst_valid` next cycle, `load_busy` = 1.
- Load 3 words starting at index DEPTH−2 → 2 words written, `load_err` = 1, `load_done` pulses, and a new `load_start` clears `load_err`.
- With `IMEM_RANGE_CHECK_EN`, fetch 0x102 and then 4·DEPTH → both return 0xE1A00000 with `fetch_fault` = 1. Without the macro, 4·DEPTH returns word 0.
- Assert `rst` during the third word of a load → all outputs return to reset values with no `load_done`, and words 0–1 of that load remain readable.
